// File: rtl/moving_average_filter.sv
// rtl/moving_average_filter.sv - runtime power-of-two boxcar average of a signed sample stream
// Define MOVING_AVERAGE_ROUNDING_EN for round-half-up output instead of floor.
module moving_average_filter #(
  parameter int DATA_WIDTH   = 14,
  parameter int MAX_LOG2_LEN = 8,
  parameter int LOG2_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [LOG2_WIDTH-1:0]        log2_len,
  input  logic signed [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         filled
);

  localparam int DEPTH = 1 << MAX_LOG2_LEN;
  localparam int SUM_W = DATA_WIDTH + MAX_LOG2_LEN;
  localparam int CNT_W = MAX_LOG2_LEN + 1;
  localparam logic [LOG2_WIDTH-1:0] MAX_LOG = LOG2_WIDTH'(MAX_LOG2_LEN);

  logic [LOG2_WIDTH-1:0]        log_clamped;
  logic [LOG2_WIDTH-1:0]        log_q;
  logic                         flush;
  logic                         accept;
  logic [CNT_W-1:0]             win_len;
  logic [MAX_LOG2_LEN-1:0]      wr_ptr;
  logic [MAX_LOG2_LEN-1:0]      rd_addr;
  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic signed [DATA_WIDTH-1:0] din_q;
  logic signed [DATA_WIDTH-1:0] old_q;
  logic signed [DATA_WIDTH-1:0] old_eff;
  logic                         v1;
  logic                         v2;
  logic signed [SUM_W-1:0]      sum;
  logic signed [SUM_W-1:0]      sum_next;
  logic [CNT_W-1:0]             fill_cnt;
  logic signed [DATA_WIDTH-1:0] avg;

  assign log_clamped = (log2_len > MAX_LOG) ? MAX_LOG : log2_len;
  assign flush       = !resetn || (log_clamped != log_q);
  assign accept      = s_axis_tvalid && !flush;
  assign win_len     = CNT_W'(1) << log_q;
  // For a full-depth window the low bits of win_len are zero, so rd_addr == wr_ptr (read-first).
  assign rd_addr     = wr_ptr - win_len[MAX_LOG2_LEN-1:0];
  assign filled      = (fill_cnt == win_len);

  // Buffer and pointer are never cleared; the zero-forced subtraction hides stale entries.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= s_axis_tdata;
      old_q       <= mem[rd_addr];
      din_q       <= s_axis_tdata;
      wr_ptr      <= wr_ptr + MAX_LOG2_LEN'(1);
    end
  end

  always_comb begin
    old_eff  = (fill_cnt < win_len) ? '0 : old_q;
    sum_next = sum + SUM_W'(din_q) - SUM_W'(old_eff);
  end

`ifdef MOVING_AVERAGE_ROUNDING_EN
  logic signed [SUM_W:0] sum_ext;
  logic signed [SUM_W:0] half;
  logic signed [SUM_W:0] rounded;

  always_comb begin
    sum_ext = {sum[SUM_W-1], sum};
    half    = '0;
    rounded = sum_ext;
    if (log_q != '0) begin
      half    = (SUM_W+1)'(1) << (log_q - LOG2_WIDTH'(1));
      rounded = (sum_ext + half) >>> log_q;
    end
  end

  assign avg = rounded[DATA_WIDTH-1:0];
`else
  logic signed [SUM_W-1:0] shifted;

  assign shifted = sum >>> log_q;
  assign avg     = shifted[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (flush) begin
      log_q         <= log_clamped;
      sum           <= '0;
      fill_cnt      <= '0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      m_axis_tvalid <= 1'b0;
      if (!resetn) begin
        m_axis_tdata <= '0;
      end
    end else begin
      v1            <= s_axis_tvalid;
      v2            <= v1;
      m_axis_tvalid <= v2;
      if (v1) begin
        sum <= sum_next;
        if (fill_cnt != win_len) begin
          fill_cnt <= fill_cnt + CNT_W'(1);
        end
      end
      if (v2) begin
        m_axis_tdata <= avg;
      end
    end
  end

endmodule

// File: tb/tb_moving_average_filter.sv
// tb/tb_moving_average_filter.sv - scoreboard bench for moving_average_filter
module tb_moving_average_filter;

  localparam int DW = 14;
  localparam int ML = 8;
  localparam int LW = 4;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic [LW-1:0]        log2_len = LW'(2);
  logic signed [DW-1:0] s_axis_tdata = '0;
  logic                 s_axis_tvalid = 1'b0;
  logic signed [DW-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 filled;

  moving_average_filter #(
    .DATA_WIDTH  (DW),
    .MAX_LOG2_LEN(ML),
    .LOG2_WIDTH  (LW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .log2_len     (log2_len),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .filled       (filled)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  longint hist[$];
  int     cur_log = 0;
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  bit     fill_stage = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  function automatic int clamp(input int l);
    return (l > ML) ? ML : l;
  endfunction

  // Zero-padded mean of the last 2^cur_log accepted samples.
  function automatic longint model_avg();
    int     n;
    longint s;
    n = 1 << cur_log;
    s = 0;
    for (int i = 0; i < n && i < hist.size(); i++) s += hist[hist.size()-1-i];
`ifdef MOVING_AVERAGE_ROUNDING_EN
    if (cur_log == 0) return s;
    return (s + (longint'(1) << (cur_log - 1))) >>> cur_log;
`else
    return s >>> cur_log;
`endif
  endfunction

  task automatic drive(input bit v, input longint d);
    bit   flushing;
    bit   new_fill;
    bit   exp_now;
    exp_t e;
    flushing      = !resetn || (clamp(int'(log2_len)) != cur_log);
    s_axis_tvalid = v;
    s_axis_tdata  = DW'(d);
    if (flushing) begin
      cur_log = clamp(int'(log2_len));
      hist.delete();
    end else if (v) begin
      hist.push_back(d);
      e.data = model_avg();
      e.cyc  = cyc + 3;
      sb.push_back(e);
    end
    new_fill = !flushing && (hist.size() >= (1 << cur_log));
    @(posedge clk);
    if (flushing) sb.delete();
    exp_now    = flushing ? 1'b0 : fill_stage;
    fill_stage = new_fill;
    #1;
    check_eq("filled", filled, exp_now);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(1'b0, 0);
    drive(1'b0, 0);
    resetn = 1'b1;
    check_eq("reset_tdata", m_axis_tdata, 0);
    check_eq("reset_tvalid", m_axis_tvalid, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      check_eq("out_valid", m_axis_tvalid, 1);
      e = sb.pop_front();
      if (m_axis_tvalid) check_eq("out_data", $signed(m_axis_tdata), e.data);
    end else if (m_axis_tvalid) begin
      check_eq("spurious_valid", m_axis_tvalid, 0);
    end
  end

  longint seq2[7] = '{1, -1, 10, -2, -5, -6, 0};
  bit     pat4[7] = '{1, 0, 0, 1, 1, 0, 1};

  function automatic longint rand_sample();
    int sel;
    sel = $urandom_range(0, 5);
    if (sel == 0) return -8192;
    if (sel == 1) return 8191;
    return longint'($urandom_range(0, 16383)) - 8192;
  endfunction

  initial begin
    log2_len = LW'(2);
    do_reset();
    check_eq("reset_filled", filled, 0);

    for (int i = 0; i < 4; i++) drive(1'b1, 4);
    idle(4);
    check_eq("t1_filled", filled, 1);

    do_reset();
    foreach (seq2[i]) drive(1'b1, seq2[i]);
    idle(4);

    log2_len = LW'(1);
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, -1);
    idle(4);

    log2_len = LW'(2);
    do_reset();
    foreach (pat4[i]) drive(pat4[i], 4);
    idle(4);

    log2_len = LW'(8);
    do_reset();
    for (int i = 0; i < 300; i++) drive(1'b1, 100);
    log2_len = LW'(12);
    for (int i = 0; i < 10; i++) drive(1'b1, 100);
    idle(4);
    check_eq("full_filled", filled, 1);
    check_eq("full_tdata", m_axis_tdata, 100);

    log2_len = LW'(2);
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, rand_sample());
    log2_len = LW'(3);
    for (int i = 0; i < 10; i++) drive(1'b1, rand_sample());
    resetn = 1'b0;
    drive(1'b1, 5);
    resetn = 1'b1;
    check_eq("midrst_tvalid", m_axis_tvalid, 0);
    check_eq("midrst_tdata", m_axis_tdata, 0);
    check_eq("midrst_filled", filled, 0);
    for (int i = 0; i < 8; i++) drive(1'b1, rand_sample());
    idle(4);

    for (int blk = 0; blk < 6; blk++) begin
      int sel;
      sel = $urandom_range(0, 2);
      log2_len = (sel == 0) ? LW'(0) : (sel == 1) ? LW'(3) : LW'(15);
      for (int i = 0; i < 25; i++) drive(1'($urandom_range(0, 3) != 0), rand_sample());
    end
    idle(5);
    check_eq("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
